// File: rtl/move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : move_sequencer
//  Description : Command-level controller for the angle-position FSM. Accepts
//                a target angle index over a valid/ready handshake, then steps
//                the angle FSM along the shortest path around the circle with
//                single-cycle moveCW/moveCCW pulses. Each step is followed by
//                a fixed dwell and a bounded wait for physicalPos to agree
//                with desiredPos.
//
//  Ports       : clk          system clock, rising edge
//                reset        synchronous active-high reset
//                cmd_valid    command source presents cmd_target
//                cmd_target   requested angle index
//                cmd_ready    command can be accepted (IDLE only)
//                abort        cancel the move in progress
//                desiredPos   current state of the angle FSM
//                physicalPos  measured motor position
//                moveCW       one-cycle clockwise step request
//                moveCCW      one-cycle counter-clockwise step request
//                busy         a move is in progress
//                done         one-cycle pulse when the target is reached
//                fault        sticky settle-timeout flag
//
//  Revision    : 1.0  initial release
// ============================================================================
module move_sequencer #(
    parameter int STATE_WIDTH    = 3,
    parameter int DWELL_CYCLES   = 4,
    parameter int SETTLE_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    input  logic [STATE_WIDTH-1:0] cmd_target,
    output logic                   cmd_ready,
    input  logic                   abort,
    input  logic [STATE_WIDTH-1:0] desiredPos,
    input  logic [STATE_WIDTH-1:0] physicalPos,
    output logic                   moveCW,
    output logic                   moveCCW,
    output logic                   busy,
    output logic                   done,
    output logic                   fault
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_EVAL   = 3'd1;
    localparam logic [2:0] S_STEP   = 3'd2;
    localparam logic [2:0] S_DWELL  = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;

    // Half-circle distance; a delta of exactly this much is routed clockwise.
    localparam logic [STATE_WIDTH-1:0] c_HALF = STATE_WIDTH'(1) << (STATE_WIDTH - 1);
    // Dwell counter is loaded with N-1 and counts down to 0, giving N cycles.
    localparam logic [15:0] c_DWELL_LOAD  = 16'(DWELL_CYCLES - 1);
    localparam logic [15:0] c_SETTLE_LAST = 16'(SETTLE_TIMEOUT - 1);

    logic [2:0]             r_state;
    logic [STATE_WIDTH-1:0] r_target;
    logic [15:0]            r_dwell_cnt;
    logic [15:0]            r_settle_cnt;
    logic                   r_move_cw;
    logic                   r_move_ccw;
    logic                   r_done;
    logic                   r_fault;

    logic [2:0]             w_next_state;
    logic [STATE_WIDTH-1:0] w_delta;
    logic                   w_go_cw;
    logic                   w_accept;
    logic                   w_eval_done;
    logic                   w_timeout;
    logic                   w_settled;

    // Modulo arithmetic handles wrap-around with no special case.
    assign w_delta   = r_target - desiredPos;
    assign w_go_cw   = (w_delta != '0) && (w_delta <= c_HALF);
    assign w_settled = (physicalPos == desiredPos);

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_eval_done  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_EVAL;
                end
            end
            S_EVAL: begin
                if (w_delta == '0) begin
                    w_eval_done  = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_STEP;
                end
            end
            S_STEP: begin
                w_next_state = S_DWELL;
            end
            S_DWELL: begin
                if (r_dwell_cnt == 16'd0) begin
                    w_next_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_settled) begin
                    w_next_state = S_EVAL;
                end else if (r_settle_cnt == c_SETTLE_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // Abort overrides every other transition and suppresses done/fault.
        if (abort && (r_state != S_IDLE)) begin
            w_next_state = S_IDLE;
            w_eval_done  = 1'b0;
            w_timeout    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_target     <= '0;
            r_dwell_cnt  <= 16'd0;
            r_settle_cnt <= 16'd0;
            r_move_cw    <= 1'b0;
            r_move_ccw   <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_target <= cmd_target;
            end

            // Pulses are registered on entry to STEP so they are high
            // exactly during the STEP cycle.
            r_move_cw  <= (w_next_state == S_STEP) &&  w_go_cw;
            r_move_ccw <= (w_next_state == S_STEP) && !w_go_cw;
            r_done     <= w_eval_done;

            if (w_accept) begin
                r_fault <= 1'b0;
            end else if (w_timeout) begin
                r_fault <= 1'b1;
            end

            if (r_state == S_STEP) begin
                r_dwell_cnt <= c_DWELL_LOAD;
            end else if ((r_state == S_DWELL) && (r_dwell_cnt != 16'd0)) begin
                r_dwell_cnt <= r_dwell_cnt - 16'd1;
            end

            if (r_state == S_DWELL) begin
                r_settle_cnt <= 16'd0;
            end else if ((r_state == S_SETTLE) && !w_settled) begin
                r_settle_cnt <= r_settle_cnt + 16'd1;
            end
        end
    end

    assign moveCW    = r_move_cw;
    assign moveCCW   = r_move_ccw;
    assign done      = r_done;
    assign fault     = r_fault;
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_move_sequencer
//  Description : Self-checking bench for move_sequencer. Emulates the angle
//                FSM and motor, applies a table of moves plus random moves,
//                and checks every cycle against timing derived from the
//                move distance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_move_sequencer;

    localparam int W  = 3;
    localparam int N  = 8;
    localparam int D  = 4;
    localparam int TO = 16;
    localparam int P  = D + 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic [W-1:0] cmd_target;
    logic         cmd_ready;
    logic         abort;
    logic [W-1:0] desiredPos;
    logic [W-1:0] physicalPos;
    logic         moveCW;
    logic         moveCCW;
    logic         busy;
    logic         done;
    logic         fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int start;       // -1 keeps the current plant position
        int tgt;
        bit track;       // physicalPos follows desiredPos
        int abort_at;    // cycle after acceptance to abort/reset, -1 none
        bit use_reset;
        int exp_pulses;  // -1 skips the pulse-count check
        bit exp_cw;
        bit keep_valid;  // hold cmd_valid high through the move
        int next_tgt;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    move_sequencer #(
        .STATE_WIDTH   (W),
        .DWELL_CYCLES  (D),
        .SETTLE_TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_target (cmd_target),
        .cmd_ready  (cmd_ready),
        .abort      (abort),
        .desiredPos (desiredPos),
        .physicalPos(physicalPos),
        .moveCW     (moveCW),
        .moveCCW    (moveCCW),
        .busy       (busy),
        .done       (done),
        .fault      (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one command. Entered in an IDLE cycle; returns at the negedge of
    // the last checked cycle.
    task automatic run_move(input int id, input vec_t v);
        int  cur, delta, n, n_eff, end_rel, last;
        bit  cw, timeout, aborted, pulse;
        bit  s_cw, s_ccw;
        int  cnt_cw, cnt_ccw;
        cur = (v.start < 0) ? int'(desiredPos) : v.start;
        if (v.start >= 0) begin
            desiredPos  = W'(v.start);
            physicalPos = W'(v.start);
        end
        delta   = (((v.tgt - cur) % N) + N) % N;
        cw      = (delta != 0) && (delta <= N / 2);
        n       = (delta == 0) ? 0 : (cw ? delta : N - delta);
        timeout = !v.track && (n > 0);
        aborted = (v.abort_at > 0);
        n_eff   = timeout ? 1 : n;
        end_rel = aborted ? v.abort_at + 1 : (timeout ? 3 + D + TO : 2 + n * P);
        last    = v.keep_valid ? end_rel : end_rel + 2;
        cnt_cw  = 0;
        cnt_ccw = 0;
        s_cw    = 1'b0;
        s_ccw   = 1'b0;

        cmd_valid  = 1'b1;
        cmd_target = W'(v.tgt);
        @(posedge clk);
        #1;
        if (v.keep_valid) cmd_target = W'(v.next_tgt);
        else              cmd_valid  = 1'b0;

        for (int rel = 1; rel <= last; rel++) begin
            abort = (rel == v.abort_at) && !v.use_reset;
            reset = (rel == v.abort_at) &&  v.use_reset;
            @(negedge clk);
            pulse = (rel >= 2) && ((rel - 2) % P == 0) && ((rel - 2) / P < n_eff) && (rel < end_rel);
            check($sformatf("v%0d.cw@%0d", id, rel),    moveCW,    pulse && cw);
            check($sformatf("v%0d.ccw@%0d", id, rel),   moveCCW,   pulse && !cw);
            check($sformatf("v%0d.done@%0d", id, rel),  done,      !aborted && !timeout && (rel == end_rel));
            check($sformatf("v%0d.busy@%0d", id, rel),  busy,      rel < end_rel);
            check($sformatf("v%0d.ready@%0d", id, rel), cmd_ready, rel >= end_rel);
            check($sformatf("v%0d.fault@%0d", id, rel), fault,     timeout && (rel >= end_rel));
            s_cw  = moveCW;
            s_ccw = moveCCW;
            if (moveCW)  cnt_cw++;
            if (moveCCW) cnt_ccw++;
            if (rel < last) begin
                @(posedge clk);
                #1;
                // Angle FSM steps on the edge ending the STEP cycle.
                if (s_cw)  desiredPos = desiredPos + W'(1);
                if (s_ccw) desiredPos = desiredPos - W'(1);
                if (v.track) physicalPos = desiredPos;
            end
        end
        abort = 1'b0;
        reset = 1'b0;
        if (v.exp_pulses >= 0) begin
            check($sformatf("v%0d.ncw", id),  cnt_cw,  v.exp_cw ? v.exp_pulses : 0);
            check($sformatf("v%0d.nccw", id), cnt_ccw, v.exp_cw ? 0 : v.exp_pulses);
        end
    endtask

    initial begin
        vec_t rv;
        //          start tgt trk abrt rst  np cw kv nxt
        vecs[0]  = '{0,  3, 1, -1, 0, 3, 1, 0, 0};  // shortest path CW
        vecs[1]  = '{1,  6, 1, -1, 0, 3, 0, 0, 0};  // wrap-around CCW
        vecs[2]  = '{0,  4, 1, -1, 0, 4, 1, 0, 0};  // half-circle tie
        vecs[3]  = '{5,  5, 1, -1, 0, 0, 1, 0, 0};  // no-op
        vecs[4]  = '{7,  0, 1, -1, 0, 1, 1, 0, 0};  // 7 -> 0 CW
        vecs[5]  = '{0,  7, 1, -1, 0, 1, 0, 0, 0};  // 0 -> 7 CCW
        vecs[6]  = '{0,  2, 0, -1, 0, 1, 1, 0, 0};  // settle timeout
        vecs[7]  = '{3,  1, 1, -1, 0, 2, 0, 0, 0};  // clears fault
        vecs[8]  = '{0,  5, 1,  4, 0, 1, 0, 0, 0};  // abort during DWELL
        vecs[9]  = '{0,  5, 1,  4, 1, 1, 0, 0, 0};  // reset during DWELL
        vecs[10] = '{0,  2, 1, -1, 0, 2, 1, 1, 7};  // valid held while busy
        vecs[11] = '{-1, 7, 1, -1, 0, 3, 0, 0, 0};  // accepted in done cycle

        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_target  = '0;
        abort       = 1'b0;
        desiredPos  = '0;
        physicalPos = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.cw",    moveCW,    0);
        check("rst.ccw",   moveCCW,   0);
        check("rst.done",  done,      0);
        check("rst.fault", fault,     0);
        check("rst.busy",  busy,      0);
        check("rst.ready", cmd_ready, 1);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_move(i, vecs[i]);
        end

        for (int i = 0; i < 24; i++) begin
            rv.start      = int'($urandom_range(0, N - 1));
            rv.tgt        = int'($urandom_range(0, N - 1));
            rv.track      = ($urandom_range(0, 5) != 0);
            rv.abort_at   = -1;
            rv.use_reset  = 1'b0;
            rv.exp_pulses = -1;
            rv.exp_cw     = 1'b0;
            rv.keep_valid = 1'b0;
            rv.next_tgt   = 0;
            run_move(100 + i, rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
